// File: rtl/dz_count.sv
// dz_count: debounced start/clear countdown sequencer feeding the dot-matrix digit bus
// Ports: clk (1 kHz scan clock), rst (async, active-high),
//        btn_start / btn_clr (raw active-high keys, asynchronous to clk),
//        num (registered count value), running (high in RUN), done (high in DONE).
// Option: define DZ_COUNT_AUTO_RELOAD_EN to reload START_VAL one count period after reaching 0.
module dz_count #(
   parameter int TICK_DIV  = 1000,
   parameter int DEB_CYC   = 20,
   parameter int START_VAL = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_clr,
   output logic [2:0] num,
   output logic       running,
   output logic       done
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYC + 1);
   localparam logic [2:0] LOAD = 3'(START_VAL);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t        r_state, w_state_n;
   logic [PW-1:0] r_pre, w_pre_n;
   logic [2:0]    w_num_n;
   logic [1:0]    r_s1, r_s2, r_deb, r_deb_q, w_press;
   logic [DW-1:0] r_cnt [2];
   logic          w_counting, w_tick;
   // key bit 0 is start, bit 1 is clear
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_deb   <= '0;
         r_deb_q <= '0;
         r_cnt   <= '{default: '0};
      end else begin
         r_s1    <= {btn_clr, btn_start};
         r_s2    <= r_s1;
         r_deb_q <= r_deb;
         for (int k = 0; k < 2; k++) begin
            // any return to the accepted level restarts qualification
            if (r_s2[k] == r_deb[k]) r_cnt[k] <= '0;
            else if (r_cnt[k] == DW'(DEB_CYC)) begin
               r_deb[k] <= r_s2[k];
               r_cnt[k] <= '0;
            end else r_cnt[k] <= r_cnt[k] + DW'(1);
         end
      end
   assign w_press = r_deb & ~r_deb_q;
   always_comb begin
`ifdef DZ_COUNT_AUTO_RELOAD_EN
      w_counting = r_state == RUN || r_state == DONE;
`else
      w_counting = r_state == RUN;
`endif
      w_tick    = w_counting && r_pre == PW'(TICK_DIV - 1);
      w_state_n = r_state;
      w_num_n   = num;
      w_pre_n   = w_counting ? (w_tick ? '0 : r_pre + PW'(1)) : r_pre;
      if (w_press[1]) begin
         w_state_n = IDLE;
         w_num_n   = LOAD;
         w_pre_n   = '0;
      end else case (r_state)
         IDLE: if (w_press[0]) begin
            w_state_n = RUN;
            w_pre_n   = '0;
         end
         RUN: begin
            if (w_tick) w_num_n = num - 3'd1;
            // a start coinciding with the final tick still ends in DONE
            if (w_tick && num == 3'd1) w_state_n = DONE;
            else if (w_press[0]) w_state_n = PAUSE;
         end
         PAUSE: if (w_press[0]) w_state_n = RUN;
         DONE: if (w_press[0]) begin
            w_state_n = RUN;
            w_num_n   = LOAD;
            w_pre_n   = '0;
         end
`ifdef DZ_COUNT_AUTO_RELOAD_EN
         else if (w_tick) begin
            w_state_n = RUN;
            w_num_n   = LOAD;
         end
`endif
         default: ;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_pre   <= '0;
         num     <= LOAD;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pre   <= w_pre_n;
         num     <= w_num_n;
         running <= w_state_n == RUN;
         done    <= w_state_n == DONE;
      end
endmodule

// File: tb/tb_dz_count.sv
// tb_dz_count: scoreboard bench for dz_count (TICK_DIV=10, DEB_CYC=4, START_VAL=5)
module tb_dz_count;
   localparam int TD = 10, DC = 4, SV = 5;
   typedef struct {int c; logic [4:0] v;} ev_t;
   logic clk = 1'b0, rst = 1'b1, btn_start = 1'b0, btn_clr = 1'b0;
   logic [2:0] num;
   logic running, done;
   int cyc = 0, n_chk = 0, n_fail = 0, t_base = 0;
   ev_t q[$];
   ev_t ev;
   logic [4:0] prev;
   dz_count #(.TICK_DIV(TD), .DEB_CYC(DC), .START_VAL(SV)) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clr(btn_clr),
      .num(num), .running(running), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // every output change must match the next scoreboard entry, at its cycle
   always @(negedge clk) begin
      if (rst) prev = {num, running, done};
      else if ({num, running, done} !== prev) begin
         prev = {num, running, done};
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change cyc=%0d got {num,run,done}=%b required no change", cyc, prev);
         end else begin
            ev = q.pop_front();
            if (ev.c != cyc || ev.v !== prev) begin
               n_fail++;
               $display("FAIL event cyc=%0d got {num,run,done}=%b required cyc=%0d %b", cyc, prev, ev.c, ev.v);
            end
         end
      end else if (q.size() != 0 && cyc > q[0].c) begin
         ev = q.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL missed_event cyc=%0d got {num,run,done}=%b required %b at cyc=%0d", cyc, prev, ev.v, ev.c);
      end
   end
   task automatic sb_push(input int c, input logic [4:0] v);
      ev_t t;
      t.c = c;
      t.v = v;
      q.push_back(t);
   endtask
   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask
   task automatic press(input int at, input logic s, input logic c, input int len);
      wait_cyc(at);
      btn_start = s;
      btn_clr = c;
      repeat (len) @(negedge clk);
      btn_start = 1'b0;
      btn_clr = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({num, running, done} !== 5'b10100) begin
         n_fail++;
         $display("FAIL reset_state got %b required %b", {num, running, done}, 5'b10100);
      end
      rst = 1'b0;
      repeat (100) @(negedge clk);
      n_chk++;
      if ({num, running, done} !== 5'b10100) begin
         n_fail++;
         $display("FAIL idle_hold got %b required %b", {num, running, done}, 5'b10100);
      end
   endtask
   task automatic test_full_count();
      int p, e;
      p = cyc + 2;
      e = p + 8;
      sb_push(e, 5'b10110);
      for (int i = 1; i <= 5; i++) sb_push(e + 10 * i, {3'(5 - i), i < 5, i == 5});
`ifdef DZ_COUNT_AUTO_RELOAD_EN
      sb_push(e + 60, 5'b10110);
      sb_push(e + 70, 5'b10010);
      sb_push(e + 80, 5'b10100);
      press(p, 1'b1, 1'b0, 10);
      press(e + 72, 1'b0, 1'b1, 10);
      wait_cyc(e + 85);
`else
      sb_push(e + 258, 5'b10100);
      press(p, 1'b1, 1'b0, 10);
      wait_cyc(e + 200);
      n_chk++;
      if ({num, running, done} !== 5'b00001) begin
         n_fail++;
         $display("FAIL done_hold got %b required %b", {num, running, done}, 5'b00001);
      end
      press(e + 250, 1'b0, 1'b1, 10);
      wait_cyc(e + 262);
`endif
   endtask
   task automatic test_bounce();
      int p;
      wait_cyc(cyc + 2);
      for (int i = 0; i < 15; i++) begin
         btn_start = ~btn_start;
         repeat (2) @(negedge clk);
      end
      btn_start = 1'b0;
      repeat (20) @(negedge clk);
      n_chk++;
      if ({num, running, done} !== 5'b10100) begin
         n_fail++;
         $display("FAIL bounce_reject got %b required %b", {num, running, done}, 5'b10100);
      end
      p = cyc + 2;
      sb_push(p + 8, 5'b10110);
      press(p, 1'b1, 1'b0, 10);
      wait_cyc(p + 12);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({num, running, done} !== 5'b10100) begin
         n_fail++;
         $display("FAIL midrun_reset got %b required %b", {num, running, done}, 5'b10100);
      end
      rst = 1'b0;
      repeat (30) @(negedge clk);
      n_chk++;
      if ({num, running, done} !== 5'b10100) begin
         n_fail++;
         $display("FAIL post_reset_idle got %b required %b", {num, running, done}, 5'b10100);
      end
   endtask
   task automatic test_pause_resume();
      int p, e;
      p = cyc + 2;
      e = p + 8;
      t_base = e;
      sb_push(e, 5'b10110);
      sb_push(e + 10, 5'b10010);
      sb_push(e + 20, 5'b01110);
      sb_push(e + 24, 5'b01100);
      sb_push(e + 82, 5'b01110);
      sb_push(e + 88, 5'b01010);
      press(p, 1'b1, 1'b0, 6);
      press(e + 16, 1'b1, 1'b0, 6);
      wait_cyc(e + 50);
      n_chk++;
      if ({num, running, done} !== 5'b01100) begin
         n_fail++;
         $display("FAIL pause_hold got %b required %b", {num, running, done}, 5'b01100);
      end
      press(e + 74, 1'b1, 1'b0, 6);
      wait_cyc(e + 89);
   endtask
   task automatic test_priority();
      int p, e;
      sb_push(t_base + 97, 5'b10100);
      press(t_base + 89, 1'b1, 1'b1, 6);
      wait_cyc(t_base + 110);
      n_chk++;
      if ({num, running, done} !== 5'b10100) begin
         n_fail++;
         $display("FAIL clr_over_start got %b required %b", {num, running, done}, 5'b10100);
      end
      p = cyc + 2;
      e = p + 8;
      sb_push(e, 5'b10110);
      for (int i = 1; i <= 4; i++) sb_push(e + 10 * i, {3'(5 - i), 2'b10});
      sb_push(e + 50, 5'b00001);
`ifdef DZ_COUNT_AUTO_RELOAD_EN
      sb_push(e + 60, 5'b10110);
`endif
      sb_push(e + 63, 5'b10100);
      press(p, 1'b1, 1'b0, 6);
      press(e + 42, 1'b1, 1'b0, 6);
      press(e + 55, 1'b0, 1'b1, 6);
      wait_cyc(e + 66);
   endtask
   initial begin
      test_reset();
      test_full_count();
      test_bounce();
      test_pause_resume();
      test_priority();
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_left got %0d pending required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dz_count.md
Name: dz_count

Overview:
- Countdown sequencer directly upstream of the dot-matrix display stage.
- Runs on the 1 kHz scan clock and debounces raw start/clear keys.
- Counts a seconds value from START_VAL down to 0 and drives the 3-bit digit bus consumed by the display (num).
- Also exports run/done status for LEDs or a buzzer.

Parameters:
- TICK_DIV, 1000: clk cycles per count step (1 s at 1 kHz); must be ≥ 2.
- DEB_CYC, 20: cycles a synchronized key level must be stable before it is accepted (20 ms); must be ≥ 1.
- START_VAL, 5: load value of num; legal range 1..7.

Ports:
- clk  in  1  1 kHz system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  raw start/pause key, active-high, asynchronous to clk.
- btn_clr  in  1  raw clear key, active-high, asynchronous to clk.
- num  out  3  current count value to the display stage, registered.
- running  out  1  high while state is RUN, registered.
- done  out  1  high while state is DONE, registered.

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, num=START_VAL, running=0, done=0;
  - prescaler=0, debounce counters=0, debounced levels=0, synchronizer flops=0.
- Key path, identical for each key:
  - 2-flop synchronizer.
  - Stability counter: reset to 0 whenever the synchronized level differs from the debounced level. When it reaches DEB_CYC, the debounced level takes the new value and the counter clears.
  - A 0→1 transition of the debounced level gives a 1-cycle press pulse; release produces nothing.
  - Latency: a raw level held high is seen as a press pulse DEB_CYC+2 cycles after the first sampling edge. State/outputs update on the next edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN (and in DONE with the option); holds its value in PAUSE.
  - tick = prescaler==TICK_DIV-1 in a counting state. The prescaler wraps to 0 on tick.
  - Cleared to 0 on any entry to RUN from IDLE or DONE, and on clr.
- FSM (clr press outranks start press, which outranks tick):
  - IDLE: start→RUN.
  - RUN: on tick, if num>1 then num−1; if num==1 then num=0 and →DONE. Start press→PAUSE.
  - RUN, start and tick in the same cycle: the decrement (or the move to DONE at num==1) is applied, and the state becomes PAUSE (or DONE).
  - PAUSE: start→RUN, prescaler resumes from its held value.
  - DONE: num holds 0; start→RUN with num=START_VAL.
  - Any state: clr→IDLE, num=START_VAL, prescaler=0.
- Outputs: running and done are registered decodes of the next state, so they change on the same edge as state. num never leaves 0..START_VAL.
- Mid-operation reset: immediate return to reset values; no held press is replayed, because the debounced levels restart at 0 and must re-qualify.

Optional Feature:
- Macro: DZ_COUNT_AUTO_RELOAD_EN.
- Defined:
  - In DONE the prescaler keeps counting.
  - On the next tick, num=START_VAL, state→RUN, done falls, running rises, giving a continuous START_VAL..0 loop with 0 shown for one period.
  - Start in DONE behaves as without the option; clr keeps priority.
- Undefined: DONE holds until a start or clr press.

Test Plan:
All scenarios use TICK_DIV=10, DEB_CYC=4, START_VAL=5.
1. Reset then idle: rst pulse, no keys for 100 cycles → num=5, running=0, done=0 throughout.
2. Full count: btn_start high 10 cycles → running=1 within 7 cycles of the press. num steps 5,4,3,2,1,0, each step 10 cycles apart. On the 0 step, done=1 and running=0; num stays 0 for 200 cycles (option off).
3. Bounce rejection: btn_start toggling every 2 cycles for 30 cycles, then low → no state change, num=5. Then a clean 10-cycle press → RUN.
4. Pause/resume: press at num=3, 4 cycles after a step → PAUSE, num=3 held for 50 cycles. Second press → the next step to 2 occurs 6 cycles after resume.
5. Priority: clr and start pressed on the same cycle during RUN at num=2 → IDLE, num=5, running=0. Start/tick collision in RUN at num=1 → num=0, done=1.
6. Option DZ_COUNT_AUTO_RELOAD_EN defined: after num reaches 0, exactly 10 cycles later num=5, running=1, done=0, and the countdown repeats.
